// File: rtl/qsys_tick_scheduler.sv
// qsys_tick_scheduler: software timer channels driven by an external tick.
// Each tick event launches a sequential scan in which one shared decrementer
// visits every channel once. Channels expire, reload or stop, and raise a
// maskable aggregated interrupt. Registers are reached over an Avalon-MM slave.
`timescale 1ns/1ps
module qsys_tick_scheduler #(
    parameter int NUM_CH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    localparam logic [1:0] LAST_INDEX = 2'(NUM_CH - 1);

    // Scanner and global state
    state_t            state_reg;
    logic [1:0]        index_reg;
    logic              tick_prev_reg;
    logic              pending_reg;
    logic              overrun_reg;
    logic              gie_reg;
    logic [NUM_CH-1:0] expired_reg;
    logic [15:0]       readdata_reg;

    // Per-channel state
    logic              irq_en_reg  [NUM_CH];
    logic              cont_reg    [NUM_CH];
    logic              running_reg [NUM_CH];
    logic [15:0]       period_reg  [NUM_CH];
    logic [15:0]       count_reg   [NUM_CH];

    logic              tick_event;
    logic              bus_write;
    logic              bus_read;
    logic              status_write;
    logic              scan_active;
    logic              last_index;
    logic              overrun_set;
    logic [15:0]       cur_count;
    logic [15:0]       cur_count_dec;
    logic              cur_expire;
    logic [NUM_CH-1:0] w1c_mask;
    logic [NUM_CH-1:0] expire_set;
    logic [NUM_CH-1:0] irq_en_vec;
    logic [15:0]       read_mux;

    assign tick_event   = tick_in && !tick_prev_reg;
    assign bus_write    = chipselect && !write_n;
    assign bus_read     = chipselect && write_n;
    assign status_write = bus_write && (address == 4'd0);
    assign scan_active  = (state_reg == SCAN);
    assign last_index   = (index_reg == LAST_INDEX);
    // A second tick arriving while one is already queued is lost.
    assign overrun_set  = scan_active && !last_index && tick_event && pending_reg;
    assign w1c_mask     = status_write ? writedata[NUM_CH-1:0] : '0;

    // The single shared decrementer looks only at the channel being scanned.
    assign cur_count     = count_reg[index_reg];
    assign cur_count_dec = cur_count - 16'd1;
    assign cur_expire    = running_reg[index_reg] && (cur_count <= 16'd1);

    assign irq      = gie_reg && |(expired_reg & irq_en_vec);
    assign readdata = readdata_reg;

    // Scanner FSM: edge detect, channel index walk, tick queueing and overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            index_reg     <= 2'd0;
            tick_prev_reg <= 1'b0;
            pending_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            tick_prev_reg <= tick_in;
            // A new overrun beats a simultaneous clear.
            overrun_reg   <= (overrun_reg && !(status_write && writedata[4])) || overrun_set;
            case (state_reg)
                IDLE: begin
                    if (tick_event) begin
                        state_reg <= SCAN;
                        index_reg <= 2'd0;
                    end
                end
                SCAN: begin
                    if (!last_index) begin
                        index_reg <= index_reg + 2'd1;
                        if (tick_event && !pending_reg) begin
                            pending_reg <= 1'b1;
                        end
                    end else if (pending_reg) begin
                        index_reg   <= 2'd0;
                        pending_reg <= tick_event;
                    end else if (tick_event) begin
                        index_reg <= 2'd0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    // Expired flags, global enable and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            expired_reg  <= '0;
            gie_reg      <= 1'b0;
            readdata_reg <= 16'd0;
        end else begin
            // A new expiry beats a simultaneous clear of the same bit.
            expired_reg <= (expired_reg & ~w1c_mask) | expire_set;
            if (bus_write && (address == 4'd1)) begin
                gie_reg <= writedata[0];
            end
            if (bus_read) begin
                readdata_reg <= read_mux;
            end
        end
    end

    // Read multiplexer over the register map; unmapped words read zero.
    always_comb begin
        read_mux = 16'd0;
        if (address == 4'd0) begin
            read_mux[NUM_CH-1:0] = expired_reg;
            read_mux[4]          = overrun_reg;
            read_mux[5]          = scan_active;
        end else if (address == 4'd1) begin
            read_mux[0] = gie_reg;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (address == 4'(2 + i)) begin
                    read_mux = {11'd0, running_reg[i], 2'b00, cont_reg[i], irq_en_reg[i]};
                end
                if (address == 4'(6 + i)) begin
                    read_mux = period_reg[i];
                end
                if (address == 4'(10 + i)) begin
                    read_mux = count_reg[i];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic ctrl_write;
            logic period_write;
            logic do_start;
            logic do_stop;
            logic scan_hit;

            assign ctrl_write   = bus_write && (address == 4'(2 + gi));
            assign period_write = bus_write && (address == 4'(6 + gi));
            assign do_start     = ctrl_write && writedata[2];
            assign do_stop      = ctrl_write && writedata[3];
            assign scan_hit     = scan_active && (index_reg == 2'(gi));
            // CPU start/stop on this channel suppresses the scanner's expiry.
            assign expire_set[gi] = scan_hit && !do_start && !do_stop && cur_expire;
            assign irq_en_vec[gi] = irq_en_reg[gi];

            // Channel control, period and count; CPU strobes win over the scanner.
            always_ff @(posedge clk) begin
                if (reset) begin
                    irq_en_reg[gi]  <= 1'b0;
                    cont_reg[gi]    <= 1'b0;
                    running_reg[gi] <= 1'b0;
                    period_reg[gi]  <= 16'd0;
                    count_reg[gi]   <= 16'd0;
                end else begin
                    if (period_write) begin
                        period_reg[gi] <= writedata;
                    end
                    if (ctrl_write) begin
                        irq_en_reg[gi] <= writedata[0];
                        cont_reg[gi]   <= writedata[1];
                    end
                    if (do_stop) begin
                        running_reg[gi] <= 1'b0;
                    end else if (do_start) begin
                        count_reg[gi]   <= period_reg[gi];
                        running_reg[gi] <= 1'b1;
                    end else if (scan_hit && running_reg[gi]) begin
                        if (cur_count <= 16'd1) begin
                            if (cont_reg[gi]) begin
                                count_reg[gi] <= period_reg[gi];
                            end else begin
                                running_reg[gi] <= 1'b0;
                            end
                        end else begin
                            count_reg[gi] <= cur_count_dec;
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_qsys_tick_scheduler.sv
// Bench for qsys_tick_scheduler: directed vector table, hand-timed corner
// sequences, and random register/tick traffic checked against a tick-level model.
`timescale 1ns/1ps
module tb_qsys_tick_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_in;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    qsys_tick_scheduler #(.NUM_CH(4)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Behavioural model: state per channel, advanced once per tick.
    logic [15:0] m_per [4];
    logic [15:0] m_cnt [4];
    logic        m_run [4];
    logic        m_cont[4];
    logic        m_ien [4];
    logic        m_exp [4];
    logic        m_gie;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_per[i] = 0; m_cnt[i] = 0; m_run[i] = 0;
            m_cont[i] = 0; m_ien[i] = 0; m_exp[i] = 0;
        end
        m_gie = 0;
    endtask

    task automatic model_tick();
        for (int i = 0; i < 4; i++) begin
            if (m_run[i]) begin
                if (m_cnt[i] <= 1) begin
                    m_exp[i] = 1;
                    if (m_cont[i]) m_cnt[i] = m_per[i];
                    else           m_run[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
    endtask

    task automatic model_write(input logic [3:0] a, input logic [15:0] d);
        int ai = int'(a);
        if (ai == 0) begin
            for (int i = 0; i < 4; i++) if (d[i]) m_exp[i] = 0;
        end else if (ai == 1) begin
            m_gie = d[0];
        end else if (ai >= 2 && ai <= 5) begin
            m_ien[ai-2]  = d[0];
            m_cont[ai-2] = d[1];
            if (d[3]) m_run[ai-2] = 0;
            else if (d[2]) begin
                m_cnt[ai-2] = m_per[ai-2];
                m_run[ai-2] = 1;
            end
        end else if (ai >= 6 && ai <= 9) begin
            m_per[ai-6] = d;
        end
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] a);
        int ai = int'(a);
        logic [15:0] r = '0;
        if (ai == 0) begin
            for (int i = 0; i < 4; i++) r[i] = m_exp[i];
        end else if (ai == 1) begin
            r[0] = m_gie;
        end else if (ai >= 2 && ai <= 5) begin
            r[0] = m_ien[ai-2];
            r[1] = m_cont[ai-2];
            r[4] = m_run[ai-2];
        end else if (ai >= 6 && ai <= 9) begin
            r = m_per[ai-6];
        end else if (ai >= 10 && ai <= 13) begin
            r = m_cnt[ai-10];
        end
        return r;
    endfunction

    function automatic logic model_irq();
        logic any = 0;
        for (int i = 0; i < 4; i++) any = any | (m_exp[i] & m_ien[i]);
        return m_gie & any;
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic tick_pulse();
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Drive tick_in from a bit pattern, one bit per cycle, then let scans drain.
    task automatic tick_pattern(input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); tick_in = pat[i];
        end
        @(negedge clk); tick_in = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    typedef struct {
        int          ch;
        logic [15:0] period;
        logic        cont;
        int          ticks;
        logic [15:0] exp_count;
        logic        exp_run;
        logic        exp_exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] got;
        logic [3:0]  a;
        logic [15:0] d;

        reset = 1'b1; tick_in = 1'b0; address = 4'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 16'd0;

        vecs[0] = '{0, 16'd3,      1'b1, 7, 16'd2,      1'b1, 1'b1};
        vecs[1] = '{2, 16'd2,      1'b0, 3, 16'd1,      1'b0, 1'b1};
        vecs[2] = '{1, 16'd0,      1'b1, 1, 16'd0,      1'b1, 1'b1};
        vecs[3] = '{3, 16'd1,      1'b0, 1, 16'd1,      1'b0, 1'b1};
        vecs[4] = '{1, 16'd5,      1'b1, 4, 16'd1,      1'b1, 1'b0};
        vecs[5] = '{3, 16'hFFFF,   1'b1, 2, 16'hFFFD,   1'b1, 1'b0};
        vecs[6] = '{0, 16'd1,      1'b1, 3, 16'd1,      1'b1, 1'b1};

        // Reset state: every word reads zero, irq low.
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            rd(a, got);
            check($sformatf("reset_reg%0d", i), got, 16'd0);
        end
        check("reset_irq", 16'(irq), 16'd0);

        // Vector table: single channel, N ticks, then count/running/expired.
        for (int v = 0; v < 7; v++) begin
            reset_dut();
            wr(4'(6 + vecs[v].ch), vecs[v].period);
            wr(4'(2 + vecs[v].ch), {13'd0, 1'b1, vecs[v].cont, 1'b1});
            for (int t = 0; t < vecs[v].ticks; t++) tick_pulse();
            rd(4'(10 + vecs[v].ch), got);
            check($sformatf("vec%0d_count", v), got, vecs[v].exp_count);
            rd(4'(2 + vecs[v].ch), got);
            check($sformatf("vec%0d_running", v), 16'(got[4]), 16'(vecs[v].exp_run));
            rd(4'd0, got);
            check($sformatf("vec%0d_expired", v), 16'(got[vecs[v].ch]), 16'(vecs[v].exp_exp));
        end

        // Interrupt latency, busy flag and W1C release.
        reset_dut();
        wr(4'd1, 16'd1);
        wr(4'd6, 16'd1);
        wr(4'd2, 16'h0007);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        check("irq_before_update", 16'(irq), 16'd0);
        address = 4'd0; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        check("irq_after_ch0", 16'(irq), 16'd1);
        check("busy_during_scan", 16'(readdata[5]), 16'd1);
        repeat (6) @(negedge clk);
        check("irq_held", 16'(irq), 16'd1);
        wr(4'd0, 16'h0001);
        check("irq_after_w1c", 16'(irq), 16'd0);

        // Pending tick consumed; then a dropped tick flags overrun.
        reset_dut();
        wr(4'd6, 16'd100);
        wr(4'd2, 16'h0006);
        tick_pattern(16'b101, 3);
        rd(4'd10, got);
        check("pending_two_scans", got, 16'd98);
        rd(4'd0, got);
        check("pending_no_overrun", 16'(got[4]), 16'd0);
        tick_pattern(16'b1010101, 7);
        rd(4'd10, got);
        check("overrun_three_scans", got, 16'd95);
        rd(4'd0, got);
        check("overrun_flag", 16'(got[4]), 16'd1);
        wr(4'd0, 16'h0010);
        rd(4'd0, got);
        check("overrun_w1c", 16'(got[4]), 16'd0);

        // CPU start collides with the scanner visiting ch1.
        reset_dut();
        wr(4'd7, 16'd1);
        wr(4'd3, 16'h0004);
        wr(4'd7, 16'd7);
        rd(4'd11, got);
        check("period_write_keeps_count", got, 16'd1);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk);
        address = 4'd3; writedata = 16'h0004; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        repeat (8) @(negedge clk);
        rd(4'd11, got);
        check("collide_count", got, 16'd7);
        rd(4'd0, got);
        check("collide_status", got, 16'd0);
        rd(4'd3, got);
        check("collide_ctrl", got, 16'h0010);

        // Reset lands on the cycle the scanner processes index 2.
        reset_dut();
        wr(4'd1, 16'd1);
        wr(4'd6, 16'd5);
        wr(4'd2, 16'h0007);
        wr(4'd8, 16'd3);
        wr(4'd4, 16'h0007);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            rd(a, got);
            check($sformatf("abort_reg%0d", i), got, 16'd0);
        end
        check("abort_irq", 16'(irq), 16'd0);

        // Random register traffic and ticks against the model.
        reset_dut();
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) < 4) begin
                tick_pulse();
                model_tick();
            end else begin
                a = 4'($urandom_range(0, 15));
                d = 16'($urandom());
                if (a >= 4'd6 && a <= 4'd9) d = 16'($urandom_range(0, 6));
                wr(a, d);
                model_write(a, d);
            end
            a = 4'($urandom_range(0, 15));
            rd(a, got);
            check($sformatf("rand%0d_reg%0d", it, a), got, model_read(a));
            check($sformatf("rand%0d_irq", it), 16'(irq), 16'(model_irq()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
